// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one memory port between instruction fetch
// and data load/store. Fetch owns the port by default; a legal data request
// steals it for exactly one DATA cycle, then the fetch is replayed with done set
// so the same request is not served twice.
module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [2:0]        dm_funct3,
  input  logic [31:0]       dm_wdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  output logic [2:0]        read_part,
  output logic [1:0]        write_part,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr_q,
  output logic              instr_valid,
  output logic [31:0]       load_q,
  output logic              load_valid,
  output logic              stall,
  output logic              fault
);

  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} state_t;

  state_t     state;
  logic       done;
  logic       dm_req;
  logic       ld_ok, st_ok, mis;
  logic [2:0] rd_part_d;
  logic [1:0] wr_part_d;
  logic       bad;

  assign dm_req = dm_rd | dm_wr;

  // funct3 decode: legality per direction, part selects, alignment check
  always_comb begin
    ld_ok     = 1'b0;
    st_ok     = 1'b0;
    mis       = 1'b0;
    rd_part_d = 3'd0;
    wr_part_d = 2'd0;
    case (dm_funct3)
      3'b000: begin ld_ok = 1'b1; st_ok = 1'b1; rd_part_d = 3'd3; wr_part_d = 2'd2; end
      3'b001: begin ld_ok = 1'b1; st_ok = 1'b1; rd_part_d = 3'd1; wr_part_d = 2'd1; mis = dm_addr[0]; end
      3'b010: begin ld_ok = 1'b1; st_ok = 1'b1; rd_part_d = 3'd0; wr_part_d = 2'd0; mis = |dm_addr[1:0]; end
      3'b100: begin ld_ok = 1'b1; rd_part_d = 3'd4; end
      3'b101: begin ld_ok = 1'b1; rd_part_d = 3'd2; mis = dm_addr[0]; end
      default: ;
    endcase
    bad = dm_req & ((dm_rd & dm_wr) | (dm_rd & ~ld_ok) | (dm_wr & ~st_ok) | mis);
  end

  assign stall = (state == DATA) | (dm_req & ~bad & ~done);

  // Port mux: fetch by default, data request while in DATA.
  // MemWrite is gated by rst so a reset mid-store never reaches the array.
  always_comb begin
    MemRead    = 1'b1;
    MemWrite   = 1'b0;
    address    = if_addr;
    data_in    = 32'd0;
    read_part  = 3'd0;
    write_part = 2'd0;
    if (state == DATA) begin
      MemRead    = dm_rd;
      MemWrite   = dm_wr & ~rst;
      address    = dm_addr;
      data_in    = dm_wdata;
      read_part  = dm_rd ? rd_part_d : 3'd0;
      write_part = dm_wr ? wr_part_d : 2'd0;
    end
  end

  // FSM, done flag and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      done        <= 1'b0;
      instr_q     <= 32'd0;
      instr_valid <= 1'b0;
      load_q      <= 32'd0;
      load_valid  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      instr_valid <= (state == FETCH) & if_req & ~stall;
      load_valid  <= (state == DATA) & dm_rd;
      fault       <= (state == FETCH) & bad & ~done;
      if ((state == FETCH) & if_req & ~stall) instr_q <= mem_rdata;
      if ((state == DATA) & dm_rd)             load_q  <= mem_rdata;
      case (state)
        FETCH: begin
          done <= 1'b0;
          if (dm_req & ~bad & ~done) state <= DATA;
        end
        DATA: begin
          done  <= 1'b1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a byte-level reference memory predicts
// fetch/load results and fault events; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_rd, dm_wr;
  logic [AW-1:0] dm_addr;
  logic [2:0]    dm_funct3;
  logic [31:0]   dm_wdata;
  logic          MemRead, MemWrite;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [2:0]    read_part;
  logic [1:0]    write_part;
  logic [31:0]   mem_rdata;
  logic [31:0]   instr_q, load_q;
  logic          instr_valid, load_valid, stall, fault;

  mem_port_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_funct3(dm_funct3),
    .dm_wdata(dm_wdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .data_in(data_in), .read_part(read_part),
    .write_part(write_part), .mem_rdata(mem_rdata), .instr_q(instr_q),
    .instr_valid(instr_valid), .load_q(load_q), .load_valid(load_valid),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  // ---------------- memory attached to the port ----------------
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[address[7:2]];
    b = w[address[1:0]*8 +: 8];
    h = w[address[1]*16 +: 16];
    case (read_part)
      3'd1:    mem_rdata = {{16{h[15]}}, h};
      3'd2:    mem_rdata = {16'd0, h};
      3'd3:    mem_rdata = {{24{b[7]}}, b};
      3'd4:    mem_rdata = {24'd0, b};
      default: mem_rdata = w;
    endcase
  end

  always @(negedge clk) begin
    if (MemWrite) begin
      case (write_part)
        2'd1:    mem[address[7:2]][address[1]*16 +: 16] = data_in[15:0];
        2'd2:    mem[address[7:2]][address[1:0]*8 +: 8] = data_in[7:0];
        default: mem[address[7:2]] = data_in;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] instr_exp_q[$];
  logic [31:0] load_exp_q[$];
  int          fault_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: access size (0 = unsupported), part selects, data values
  function automatic int unsigned acc_size(bit rd, bit wr, logic [2:0] f3);
    if (rd && wr) return 0;
    if (rd) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    if (wr) begin
      case (f3)
        3'd0:    return 1;
        3'd1:    return 2;
        3'd2:    return 4;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic logic [2:0] exp_rpart(logic [2:0] f3);
    case (f3)
      3'd0: return 3'd3;
      3'd1: return 3'd1;
      3'd4: return 3'd4;
      3'd5: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_wpart(logic [2:0] f3);
    case (f3)
      3'd0: return 2'd2;
      3'd1: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(int unsigned a, logic [2:0] f3);
    logic [31:0] w, b, h;
    w = ref_mem[a / 4];
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> ((a % 4) * 8)) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(int unsigned a, int unsigned sz, logic [31:0] wd);
    logic [31:0] m;
    int unsigned sh;
    m  = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    sh = (a % 4) * 8;
    ref_mem[a / 4] = (ref_mem[a / 4] & ~(m << sh)) | ((wd & m) << sh);
  endtask

  // Monitor: pop on every presented result
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid) begin
        if (instr_exp_q.size() == 0) chk("instr_unexpected", 32'd1, 32'd0);
        else chk("instr_q", instr_q, instr_exp_q.pop_front());
      end
      if (load_valid) begin
        if (load_exp_q.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
        else chk("load_q", load_q, load_exp_q.pop_front());
      end
      if (fault) begin
        if (fault_exp_q.size() == 0) chk("fault_unexpected", 32'd1, 32'd0);
        else chk("fault", {31'd0, fault}, fault_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit ifr, input logic [AW-1:0] ia, input bit rd, input bit wr,
                       input logic [2:0] f3, input logic [AW-1:0] da, input logic [31:0] wd);
    int unsigned sz;
    bit bad, go;
    int nst;
    @(posedge clk); #1;
    if_req = ifr; if_addr = ia; dm_rd = rd; dm_wr = wr;
    dm_funct3 = f3; dm_addr = da; dm_wdata = wd;
    sz  = acc_size(rd, wr, f3);
    bad = (rd || wr) && (sz == 0 || (int'(da) % sz) != 0);
    go  = (rd || wr) && !bad;
    if (bad) fault_exp_q.push_back(1);
    if (go && rd) load_exp_q.push_back(ref_load(int'(da), f3));
    if (go && wr) ref_store(int'(da), sz, wd);
    if (ifr) instr_exp_q.push_back(ref_mem[ia[7:2]]);
    nst = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      nst++;
      if (nst >= 2) chk("instr_valid_in_stall", {31'd0, instr_valid}, 32'd0);
      if (nst == 2) begin
        chk("data_addr", {24'd0, address}, {24'd0, da});
        chk("data_MemRead", {31'd0, MemRead}, {31'd0, rd});
        chk("data_MemWrite", {31'd0, MemWrite}, {31'd0, wr});
        if (rd) chk("read_part", {29'd0, read_part}, {29'd0, exp_rpart(f3)});
        if (wr) begin
          chk("write_part", {30'd0, write_part}, {30'd0, exp_wpart(f3)});
          chk("data_in", data_in, wd);
        end
      end
      if (nst > 4) begin
        chk("stall_timeout", 32'(nst), 32'd2);
        break;
      end
    end
    chk("stall_cycles", 32'(nst), go ? 32'd2 : 32'd0);
    chk("fetch_MemRead", {31'd0, MemRead}, 32'd1);
    chk("fetch_MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("fetch_addr", {24'd0, address}, {24'd0, ia});
    chk("fetch_parts", {27'd0, read_part, write_part}, 32'd0);
    if (go) begin
      chk("load_valid_timing", {31'd0, load_valid}, {31'd0, rd});
      chk("instr_valid_after_data", {31'd0, instr_valid}, 32'd0);
    end
  endtask

  task automatic idle();
    do_op(1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0;
    dm_addr = '0; dm_funct3 = 3'd0; dm_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h0020_8233; mem[20] = 32'd17; mem[21] = 32'd9; mem[22] = 32'd25;
    ref_mem[3] = mem[3]; ref_mem[20] = mem[20]; ref_mem[21] = mem[21]; ref_mem[22] = mem[22];

    @(negedge clk);
    chk("rst_outputs", {instr_valid, load_valid, fault, 29'd0}, 32'd0);
    chk("rst_instr_q", instr_q, 32'd0);
    chk("rst_load_q", load_q, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // directed scenarios
    do_op(1'b1, 8'h0C, 0, 0, 3'd0, 8'h00, 32'd0);   // fetch only
    do_op(1'b1, 8'h10, 1, 0, 3'b010, 8'h50, 32'd0); // LW -> 17
    do_op(1'b0, 8'h14, 1, 0, 3'b100, 8'h58, 32'd0); // LBU back-to-back -> 25
    do_op(1'b0, 8'h18, 0, 1, 3'b000, 8'h55, 32'hAB);// SB
    chk("sb_word21", mem[21], 32'h0000_AB09);
    do_op(1'b1, 8'h1C, 1, 0, 3'b001, 8'h51, 32'd0); // misaligned LH
    idle();

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      bit rd, wr;
      logic [2:0] f3;
      logic [AW-1:0] da;
      int unsigned sz;
      r  = $urandom_range(0, 9);
      rd = 0; wr = 0; f3 = 3'($urandom); da = AW'($urandom);
      if (r <= 3) begin
        rd = 1;
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else if (r <= 6) begin
        wr = 1; f3 = 3'($urandom_range(0, 2));
      end else if (r == 7) begin
        rd = $urandom_range(0, 1); wr = !rd;
      end else if (r == 8) begin
        rd = 1; wr = 1;
      end
      if (r <= 6) begin
        sz = acc_size(rd, wr, f3);
        da = AW'(int'(da) - (int'(da) % sz));
      end
      do_op(1'($urandom), AW'({$urandom_range(0, 63), 2'b00}), rd, wr, f3, da, $urandom);
    end
    idle();
    idle();

    // reset asserted while a store sits in DATA
    do_op(1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 32'd0);
    @(posedge clk); #1;
    dm_wr = 1; dm_funct3 = 3'b010; dm_addr = 8'h78; dm_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("pre_rst_MemWrite", {31'd0, MemWrite}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_MemWrite_drop", {31'd0, MemWrite}, 32'd0);
    chk("rst_mid_outputs", {instr_valid, load_valid, fault, 29'd0}, 32'd0);
    chk("rst_mid_q", instr_q | load_q, 32'd0);
    @(negedge clk);
    dm_wr = 0;
    @(posedge clk); #1 rst = 1'b0;
    idle();
    idle();

    for (int i = 0; i < 64; i++)
      if (mem[i] !== ref_mem[i]) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);
    checks++;
    chk("instr_q_drained", 32'(instr_exp_q.size()), 32'd0);
    chk("load_q_drained", 32'(load_exp_q.size()), 32'd0);
    chk("fault_q_drained", 32'(fault_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
